multicycle_control: RTL and testbench

Main sequencer for the multicycle RV32I datapath. It walks each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It drives the instruction-register, PC, ALU-operand, writeback and memory-request controls around the shared register file, ALU, immediate generator and single memory port. Illegal opcodes park the core in HALT until reset.

---
 rtl/multicycle_pkg.sv | 67 ++++++
 rtl/multicycle_control_decoder.sv | 35 +++
 rtl/multicycle_control.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// ============================================================================
// Module      : multicycle_pkg
// Description : Shared widths, state encoding, opcodes, instruction-class
//               indices and control-field encodings for the multicycle core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

    localparam int WIDTH_DATA = 32;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_ialu  = 7'b0010011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    localparam logic [6:0] c_op_rtype = 7'b0110011;

    // Bit positions inside the one-hot instruction-class vector
    localparam int c_cls_load   = 0;
    localparam int c_cls_ialu   = 1;
    localparam int c_cls_store  = 2;
    localparam int c_cls_branch = 3;
    localparam int c_cls_lui    = 4;
    localparam int c_cls_auipc  = 5;
    localparam int c_cls_jal    = 6;
    localparam int c_cls_jalr   = 7;
    localparam int c_cls_rtype  = 8;
    localparam int c_num_cls    = 9;

    typedef logic [c_num_cls-1:0] inst_class_t;

    localparam logic [1:0] c_pcsrc_pc4  = 2'd0;
    localparam logic [1:0] c_pcsrc_imm  = 2'd1;
    localparam logic [1:0] c_pcsrc_alu  = 2'd2;

    localparam logic [1:0] c_srca_rs1   = 2'd0;
    localparam logic [1:0] c_srca_pc    = 2'd1;
    localparam logic [1:0] c_srca_zero  = 2'd2;

    localparam logic       c_srcb_rs2   = 1'b0;
    localparam logic       c_srcb_imm   = 1'b1;

    localparam logic [1:0] c_aluop_add  = 2'd0;
    localparam logic [1:0] c_aluop_func = 2'd1;
    localparam logic [1:0] c_aluop_cmp  = 2'd2;

    localparam logic [1:0] c_wb_alu     = 2'd0;
    localparam logic [1:0] c_wb_mem     = 2'd1;
    localparam logic [1:0] c_wb_pc4     = 2'd2;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_decoder.sv
// ============================================================================
// Module      : opcode_decoder
// Description : Maps a 7-bit RV32I opcode to a one-hot class plus illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module opcode_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0]  opcode_i,
    output inst_class_t inst_class_o,
    output logic        illegal_o
);

    always_comb begin
        inst_class_o = '0;
        illegal_o    = 1'b0;
        case (opcode_i)
            c_op_load:   inst_class_o[c_cls_load]   = 1'b1;
            c_op_ialu:   inst_class_o[c_cls_ialu]   = 1'b1;
            c_op_store:  inst_class_o[c_cls_store]  = 1'b1;
            c_op_branch: inst_class_o[c_cls_branch] = 1'b1;
            c_op_lui:    inst_class_o[c_cls_lui]    = 1'b1;
            c_op_auipc:  inst_class_o[c_cls_auipc]  = 1'b1;
            c_op_jal:    inst_class_o[c_cls_jal]    = 1'b1;
            c_op_jalr:   inst_class_o[c_cls_jalr]   = 1'b1;
            c_op_rtype:  inst_class_o[c_cls_rtype]  = 1'b1;
            default:     illegal_o                  = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the
//               multicycle RV32I datapath; illegal opcodes park it in HALT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int WIDTH_DATA = 32
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [6:0] opcode_i,
    input  logic       branchTaken_i,
    input  logic       memAck_i,
    output logic       memReq_o,
    output logic       memWe_o,
    output logic       memSel_o,
    output logic       irWrite_o,
    output logic       pcWrite_o,
    output logic [1:0] pcSrc_o,
    output logic [1:0] aluSrcA_o,
    output logic       aluSrcB_o,
    output logic [1:0] aluOp_o,
    output logic       regWrite_o,
    output logic [1:0] wbSel_o,
    output logic       instRetired_o,
    output logic       halted_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] c_st_fetch     = ST_FETCH;
    localparam logic [2:0] c_st_decode    = ST_DECODE;
    localparam logic [2:0] c_st_execute   = ST_EXECUTE;
    localparam logic [2:0] c_st_memory    = ST_MEMORY;
    localparam logic [2:0] c_st_writeback = ST_WRITEBACK;
    localparam logic [2:0] c_st_halt      = ST_HALT;

    generate
        if (WIDTH_DATA != multicycle_pkg::WIDTH_DATA) begin : g_width_check
            $error("WIDTH_DATA must match multicycle_pkg::WIDTH_DATA");
        end
    endgenerate

    inst_class_t w_cls;
    logic        w_illegal;
    logic [2:0]  r_state;
    logic [2:0]  w_next;

    opcode_decoder u_decoder (
        .opcode_i     (opcode_i),
        .inst_class_o (w_cls),
        .illegal_o    (w_illegal)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_fetch: begin
                if (memAck_i) w_next = c_st_decode;
            end
            c_st_decode: begin
                w_next = w_illegal ? c_st_halt : c_st_execute;
            end
            c_st_execute: begin
                if (w_cls[c_cls_branch])
                    w_next = c_st_fetch;
                else if (w_cls[c_cls_load] || w_cls[c_cls_store])
                    w_next = c_st_memory;
                else
                    w_next = c_st_writeback;
            end
            c_st_memory: begin
                if (memAck_i) w_next = w_cls[c_cls_store] ? c_st_fetch : c_st_writeback;
            end
            c_st_writeback: w_next = c_st_fetch;
            c_st_halt:      w_next = c_st_halt;
            default:        w_next = c_st_fetch;
        endcase
    end

    // Every output is forced low while reset is asserted, including the Mealy ones
    always_comb begin
        memReq_o      = 1'b0;
        memWe_o       = 1'b0;
        memSel_o      = 1'b0;
        irWrite_o     = 1'b0;
        pcWrite_o     = 1'b0;
        pcSrc_o       = c_pcsrc_pc4;
        aluSrcA_o     = c_srca_rs1;
        aluSrcB_o     = c_srcb_rs2;
        aluOp_o       = c_aluop_add;
        regWrite_o    = 1'b0;
        wbSel_o       = c_wb_alu;
        instRetired_o = 1'b0;
        halted_o      = 1'b0;
        state_o       = 3'd0;
        if (rstn_i) begin
            state_o = r_state;
            case (r_state)
                c_st_fetch: begin
                    memReq_o  = 1'b1;
                    irWrite_o = memAck_i;
                end
                c_st_execute: begin
                    if (w_cls[c_cls_rtype]) begin
                        aluOp_o = c_aluop_func;
                    end else if (w_cls[c_cls_ialu]) begin
                        aluSrcB_o = c_srcb_imm;
                        aluOp_o   = c_aluop_func;
                    end else if (w_cls[c_cls_lui]) begin
                        aluSrcA_o = c_srca_zero;
                        aluSrcB_o = c_srcb_imm;
                    end else if (w_cls[c_cls_auipc]) begin
                        aluSrcA_o = c_srca_pc;
                        aluSrcB_o = c_srcb_imm;
                    end else if (w_cls[c_cls_jalr] || w_cls[c_cls_load] || w_cls[c_cls_store]) begin
                        aluSrcB_o = c_srcb_imm;
                    end else if (w_cls[c_cls_branch]) begin
                        aluOp_o       = c_aluop_cmp;
                        pcWrite_o     = 1'b1;
                        pcSrc_o       = branchTaken_i ? c_pcsrc_imm : c_pcsrc_pc4;
                        instRetired_o = 1'b1;
                    end
                end
                c_st_memory: begin
                    memReq_o = 1'b1;
                    memSel_o = 1'b1;
                    memWe_o  = w_cls[c_cls_store];
                    if (w_cls[c_cls_store] && memAck_i) begin
                        pcWrite_o     = 1'b1;
                        instRetired_o = 1'b1;
                    end
                end
                c_st_writeback: begin
                    regWrite_o    = 1'b1;
                    pcWrite_o     = 1'b1;
                    instRetired_o = 1'b1;
                    if (w_cls[c_cls_load])
                        wbSel_o = c_wb_mem;
                    else if (w_cls[c_cls_jal] || w_cls[c_cls_jalr])
                        wbSel_o = c_wb_pc4;
                    if (w_cls[c_cls_jal])
                        pcSrc_o = c_pcsrc_imm;
                    else if (w_cls[c_cls_jalr])
                        pcSrc_o = c_pcsrc_alu;
                end
                c_st_halt: halted_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed cycle-by-cycle check of every control output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       clk;
    logic       rstn_i;
    logic [6:0] opcode_i;
    logic       branchTaken_i;
    logic       memAck_i;
    logic       memReq_o, memWe_o, memSel_o, irWrite_o, pcWrite_o;
    logic [1:0] pcSrc_o, aluSrcA_o, aluOp_o, wbSel_o;
    logic       aluSrcB_o, regWrite_o, instRetired_o, halted_o;
    logic [2:0] state_o;
    logic [19:0] w_obs;

    int n_vec = 0;
    int n_err = 0;

    multicycle_control #(.WIDTH_DATA(32)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .opcode_i      (opcode_i),
        .branchTaken_i (branchTaken_i),
        .memAck_i      (memAck_i),
        .memReq_o      (memReq_o),
        .memWe_o       (memWe_o),
        .memSel_o      (memSel_o),
        .irWrite_o     (irWrite_o),
        .pcWrite_o     (pcWrite_o),
        .pcSrc_o       (pcSrc_o),
        .aluSrcA_o     (aluSrcA_o),
        .aluSrcB_o     (aluSrcB_o),
        .aluOp_o       (aluOp_o),
        .regWrite_o    (regWrite_o),
        .wbSel_o       (wbSel_o),
        .instRetired_o (instRetired_o),
        .halted_o      (halted_o),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_obs = {memReq_o, memWe_o, memSel_o, irWrite_o, pcWrite_o, pcSrc_o,
                    aluSrcA_o, aluSrcB_o, aluOp_o, regWrite_o, wbSel_o,
                    instRetired_o, halted_o, state_o};

    function automatic logic [19:0] ov(
        input logic req, input logic we, input logic sel, input logic irw,
        input logic pcw, input logic [1:0] pcs, input logic [1:0] sa,
        input logic sb, input logic [1:0] op, input logic rw,
        input logic [1:0] wb, input logic ret, input logic hlt,
        input logic [2:0] st);
        return {req, we, sel, irw, pcw, pcs, sa, sb, op, rw, wb, ret, hlt, st};
    endfunction

    function automatic logic [19:0] e_fetch(input logic irw);
        return ov(1, 0, 0, irw, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 3'd0);
    endfunction
    function automatic logic [19:0] e_dec();
        return ov(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 3'd1);
    endfunction
    function automatic logic [19:0] e_exe(input logic [1:0] sa, input logic sb, input logic [1:0] op);
        return ov(0, 0, 0, 0, 0, 2'd0, sa, sb, op, 0, 2'd0, 0, 0, 3'd2);
    endfunction
    function automatic logic [19:0] e_br(input logic [1:0] pcs);
        return ov(0, 0, 0, 0, 1, pcs, 2'd0, 0, 2'd2, 0, 2'd0, 1, 0, 3'd2);
    endfunction
    function automatic logic [19:0] e_mem(input logic we, input logic done);
        return ov(1, we, 1, 0, done, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, done, 0, 3'd3);
    endfunction
    function automatic logic [19:0] e_wb(input logic [1:0] wb, input logic [1:0] pcs);
        return ov(0, 0, 0, 0, 1, pcs, 2'd0, 0, 2'd0, 1, wb, 1, 0, 3'd4);
    endfunction
    function automatic logic [19:0] e_halt();
        return ov(0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 1, 3'd5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, check outputs, advance one clock
    task automatic step(input string tag, input logic ack, input logic taken, input logic [19:0] exp);
        memAck_i      = ack;
        branchTaken_i = taken;
        #1;
        check(tag, {12'd0, w_obs}, {12'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic front(input string tag, input logic [6:0] op);
        opcode_i = op;
        step({tag, "_fetch"}, 1'b1, 1'b0, e_fetch(1'b1));
        step({tag, "_dec"},   1'b1, 1'b0, e_dec());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn_i        = 1'b0;
        memAck_i      = 1'b1;
        branchTaken_i = 1'b1;
        opcode_i      = 7'h13;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {12'd0, w_obs}, 32'd0);
        rstn_i = 1'b1;
        step("release_fetch", 1'b0, 1'b0, e_fetch(1'b0));

        // ADDI x1,x0,5
        front("addi", 7'h13);
        step("addi_exe", 1'b1, 1'b0, e_exe(2'd0, 1'b1, 2'd1));
        step("addi_wb",  1'b1, 1'b0, e_wb(2'd0, 2'd0));

        // LW with three wait cycles on the data access
        front("lw", 7'h03);
        step("lw_exe",   1'b0, 1'b0, e_exe(2'd0, 1'b1, 2'd0));
        step("lw_mem_w0", 1'b0, 1'b0, e_mem(1'b0, 1'b0));
        step("lw_mem_w1", 1'b0, 1'b0, e_mem(1'b0, 1'b0));
        step("lw_mem_w2", 1'b0, 1'b0, e_mem(1'b0, 1'b0));
        step("lw_mem_ack", 1'b1, 1'b0, e_mem(1'b0, 1'b0));
        step("lw_wb",    1'b1, 1'b0, e_wb(2'd1, 2'd0));

        front("beq_t", 7'h63);
        step("beq_t_exe", 1'b1, 1'b1, e_br(2'd1));
        front("beq_n", 7'h63);
        step("beq_n_exe", 1'b1, 1'b0, e_br(2'd0));

        front("sw", 7'h23);
        step("sw_exe",   1'b1, 1'b0, e_exe(2'd0, 1'b1, 2'd0));
        step("sw_mem_w0", 1'b0, 1'b0, e_mem(1'b1, 1'b0));
        step("sw_mem_ack", 1'b1, 1'b0, e_mem(1'b1, 1'b1));

        front("jalr", 7'h67);
        step("jalr_exe", 1'b1, 1'b0, e_exe(2'd0, 1'b1, 2'd0));
        step("jalr_wb",  1'b1, 1'b0, e_wb(2'd2, 2'd2));

        front("jal", 7'h6F);
        step("jal_exe",  1'b1, 1'b0, e_exe(2'd0, 1'b0, 2'd0));
        step("jal_wb",   1'b1, 1'b0, e_wb(2'd2, 2'd1));

        front("lui", 7'h37);
        step("lui_exe",  1'b1, 1'b0, e_exe(2'd2, 1'b1, 2'd0));
        step("lui_wb",   1'b1, 1'b0, e_wb(2'd0, 2'd0));

        front("auipc", 7'h17);
        step("auipc_exe", 1'b1, 1'b0, e_exe(2'd1, 1'b1, 2'd0));
        step("auipc_wb", 1'b1, 1'b0, e_wb(2'd0, 2'd0));

        front("add", 7'h33);
        step("add_exe",  1'b1, 1'b0, e_exe(2'd0, 1'b0, 2'd1));
        step("add_wb",   1'b1, 1'b0, e_wb(2'd0, 2'd0));

        // Illegal opcode parks the core; ack is ignored there
        front("ill", 7'h7F);
        step("halt_0", 1'b1, 1'b1, e_halt());
        step("halt_1", 1'b1, 1'b1, e_halt());
        rstn_i = 1'b0;
        #1;
        check("halt_rst_async", {12'd0, w_obs}, 32'd0);
        @(posedge clk);
        #1;
        check("halt_rst_held", {12'd0, w_obs}, 32'd0);
        rstn_i = 1'b1;
        step("halt_rst_fetch", 1'b0, 1'b0, e_fetch(1'b0));

        // Reset during a pending load abandons it
        front("lw2", 7'h03);
        step("lw2_exe",  1'b0, 1'b0, e_exe(2'd0, 1'b1, 2'd0));
        step("lw2_mem",  1'b0, 1'b0, e_mem(1'b0, 1'b0));
        rstn_i = 1'b0;
        memAck_i = 1'b1;
        #1;
        check("mem_rst_async", {12'd0, w_obs}, 32'd0);
        @(posedge clk);
        #1;
        rstn_i = 1'b1;
        step("mem_rst_fetch", 1'b1, 1'b0, e_fetch(1'b1));
        step("mem_rst_dec",   1'b0, 1'b0, e_dec());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
